// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arithmetic ops plus a WIDTH-cycle shift-add multiply.
// Results and flags are registered and held until the consumer takes them.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 accept;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH:0]       mul_sum;
  logic [CNT_W-1:0]     cnt;
  logic                 mul_last;
  logic [WIDTH:0]       add_full;
  logic [WIDTH:0]       sub_full;
  logic [WIDTH-1:0]     res;
  logic                 res_carry;
  logic                 res_ovf;

  // Pure state decode; gated by rst so nothing is accepted during reset.
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // One multiplier bit per cycle: add multiplicand to the high half, shift right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign acc_next = {mul_sum, acc[WIDTH-1:1]};
  assign mul_last = (cnt == CNT_W'(WIDTH - 1));

  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  // Single-cycle result straight from the port operands at accept time.
  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        res       = add_full[WIDTH-1:0];
        res_carry = add_full[WIDTH];
        res_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SUB: begin
        res       = sub_full[WIDTH-1:0];
        res_carry = !sub_full[WIDTH];
        res_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        res       = {a[WIDTH-2:0], 1'b0};
        res_carry = a[WIDTH-1];
      end
      OP_SHR: begin
        res       = {1'b0, a[WIDTH-1:1]};
        res_carry = a[0];
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (op == OP_MUL) ? BUSY : DONE;
      BUSY: if (mul_last) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs; only written at accept or on the last MUL step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      y_hi      <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= (state_next == DONE);
      if (accept) begin
        mcand <= a;
        acc   <= {{WIDTH{1'b0}}, b};
        cnt   <= '0;
        if (op != OP_MUL) begin
          y     <= res;
          y_hi  <= '0;
          carry <= res_carry;
          zero  <= (res == '0);
          neg   <= res[WIDTH-1];
          ovf   <= res_ovf;
        end
      end else if (state == BUSY) begin
        acc <= acc_next;
        cnt <= cnt + CNT_W'(1);
        if (mul_last) begin
          y     <= acc_next[WIDTH-1:0];
          y_hi  <= acc_next[2*WIDTH-1:WIDTH];
          carry <= (acc_next[2*WIDTH-1:WIDTH] != '0);
          zero  <= (acc_next[WIDTH-1:0] == '0);
          neg   <= acc_next[WIDTH-1];
          ovf   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=8 and WIDTH=16 instances, vector table plus reset and backpressure sequences.
module tb_alu_seq;

  typedef struct {
    int          id;
    int          sel;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [31:0] y_hi;
    logic [3:0]  f;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic        ov;
    logic        ir;
    logic [31:0] y;
    logic [31:0] y_hi;
    logic [3:0]  f;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, y8, y_hi8;
  logic [2:0] op8 = '0;
  logic       carry8, zero8, neg8, ovf8;

  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, y16, y_hi16;
  logic [2:0]  op16 = '0;
  logic        carry16, zero16, neg16, ovf16;

  int n_chk  = 0;
  int n_fail = 0;
  vec_t exp_q[$];
  vec_t tbl[16];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .y(y8), .y_hi(y_hi8), .carry(carry8), .zero(zero8), .neg(neg8), .ovf(ovf8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
    .y(y16), .y_hi(y_hi16), .carry(carry16), .zero(zero16), .neg(neg16), .ovf(ovf16)
  );

  function automatic vec_t mk(int id, int sel, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] y, logic [31:0] yh, logic [3:0] f, int lat, int hold);
    vec_t v;
    v.id = id; v.sel = sel; v.op = op; v.a = a; v.b = b;
    v.y = y; v.y_hi = yh; v.f = f; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  function automatic obs_t get(int sel);
    obs_t o;
    if (sel == 0) begin
      o.ov = out_valid8; o.ir = in_ready8; o.y = 32'(y8); o.y_hi = 32'(y_hi8);
      o.f = {carry8, zero8, neg8, ovf8};
    end else begin
      o.ov = out_valid16; o.ir = in_ready16; o.y = 32'(y16); o.y_hi = 32'(y_hi16);
      o.f = {carry16, zero16, neg16, ovf16};
    end
    return o;
  endfunction

  task automatic set_in(int sel, logic iv, logic [2:0] o, logic [31:0] av, logic [31:0] bv);
    if (sel == 0) begin
      in_valid8 = iv; op8 = o; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      in_valid16 = iv; op16 = o; a16 = av[15:0]; b16 = bv[15:0];
    end
  endtask

  task automatic set_or(int sel, logic r);
    if (sel == 0) out_ready8 = r;
    else          out_ready16 = r;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic scramble(int sel);
    set_in(sel, 1'b0, 3'($urandom), $urandom, $urandom);
  endtask

  // Called at a negedge; returns at a negedge with the result consumed.
  task automatic run_op(vec_t v);
    obs_t o;
    vec_t e;
    int   lat;
    bit   seen;
    o = get(v.sel);
    for (int k = 0; k < 20 && !o.ir; k++) begin
      @(posedge clk); @(negedge clk);
      o = get(v.sel);
    end
    chk($sformatf("v%0d_in_ready_idle", v.id), 32'(o.ir), 32'd1);
    set_in(v.sel, 1'b1, v.op, v.a, v.b);
    exp_q.push_back(v);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      scramble(v.sel);
      o = get(v.sel);
      if (o.ov) seen = 1'b1;
    end
    e = exp_q.pop_front();
    chk($sformatf("v%0d_out_valid_seen", e.id), 32'(seen), 32'd1);
    chk($sformatf("v%0d_latency", e.id), 32'(lat), 32'(e.lat));
    chk($sformatf("v%0d_y", e.id), o.y, e.y);
    chk($sformatf("v%0d_y_hi", e.id), o.y_hi, e.y_hi);
    chk($sformatf("v%0d_flags_czno", e.id), 32'(o.f), 32'(e.f));
    chk($sformatf("v%0d_in_ready_busy", e.id), 32'(o.ir), 32'd0);
    for (int i = 0; i < e.hold; i++) begin
      if (i == 1) set_in(e.sel, 1'b1, 3'b000, 32'h11, 32'h22);
      else        scramble(e.sel);
      @(posedge clk); @(negedge clk);
      o = get(e.sel);
      chk($sformatf("v%0d_hold%0d_valid", e.id, i), 32'(o.ov), 32'd1);
      chk($sformatf("v%0d_hold%0d_in_ready", e.id, i), 32'(o.ir), 32'd0);
      chk($sformatf("v%0d_hold%0d_y", e.id, i), o.y, e.y);
      chk($sformatf("v%0d_hold%0d_flags", e.id, i), 32'(o.f), 32'(e.f));
    end
    scramble(e.sel);
    set_or(e.sel, 1'b1);
    @(posedge clk); @(negedge clk);
    set_or(e.sel, 1'b0);
    o = get(e.sel);
    chk($sformatf("v%0d_valid_after_take", e.id), 32'(o.ov), 32'd0);
    chk($sformatf("v%0d_in_ready_after_take", e.id), 32'(o.ir), 32'd1);
    if (e.hold > 0) begin
      @(posedge clk); @(negedge clk);
      o = get(e.sel);
      chk($sformatf("v%0d_ignored_pulse_no_result", e.id), 32'(o.ov), 32'd0);
    end
  endtask

  initial begin
    obs_t o;
    bit   any_valid;

    //            id sel op      a         b         y         y_hi      czno     lat hold
    tbl[0]  = mk( 0, 0, 3'b000, 3,        5,        8,        0,        4'b0000, 1,  5);
    tbl[1]  = mk( 1, 0, 3'b000, 200,      100,      44,       0,        4'b1000, 1,  0);
    tbl[2]  = mk( 2, 0, 3'b000, 100,      100,      200,      0,        4'b0011, 1,  0);
    tbl[3]  = mk( 3, 0, 3'b100, 5,        7,        254,      0,        4'b1010, 1,  0);
    tbl[4]  = mk( 4, 0, 3'b100, 9,        9,        0,        0,        4'b0100, 1,  0);
    tbl[5]  = mk( 5, 0, 3'b001, 3,        5,        1,        0,        4'b0000, 1,  0);
    tbl[6]  = mk( 6, 0, 3'b010, 7,        8,        15,       0,        4'b0000, 1,  0);
    tbl[7]  = mk( 7, 0, 3'b011, 15,       1,        14,       0,        4'b0000, 1,  0);
    tbl[8]  = mk( 8, 0, 3'b101, 'h81,     0,        'h02,     0,        4'b1000, 1,  0);
    tbl[9]  = mk( 9, 0, 3'b110, 'h81,     0,        'h40,     0,        4'b1000, 1,  0);
    tbl[10] = mk(10, 0, 3'b100, 'h80,     1,        'h7F,     0,        4'b0001, 1,  0);
    tbl[11] = mk(11, 0, 3'b111, 200,      200,      'h40,     'h9C,     4'b1000, 9,  0);
    tbl[12] = mk(12, 0, 3'b111, 15,       17,       255,      0,        4'b0010, 9,  0);
    tbl[13] = mk(13, 0, 3'b111, 0,        5,        0,        0,        4'b0100, 9,  0);
    tbl[14] = mk(14, 1, 3'b000, 'hFFFF,   1,        0,        0,        4'b1100, 1,  0);
    tbl[15] = mk(15, 1, 3'b111, 'hFFFF,   'hFFFF,   1,        'hFFFE,   4'b1000, 17, 0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    o = get(0);
    chk("rst_in_ready8", 32'(o.ir), 32'd0);
    chk("rst_out_valid8", 32'(o.ov), 32'd0);
    chk("rst_y8", o.y, 32'd0);
    chk("rst_y_hi8", o.y_hi, 32'd0);
    chk("rst_flags8", 32'(o.f), 32'd0);
    o = get(1);
    chk("rst_in_ready16", 32'(o.ir), 32'd0);
    chk("rst_out_valid16", 32'(o.ov), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_op(tbl[i]);

    // Reset four cycles into a MUL aborts it with no result
    set_in(0, 1'b1, 3'b111, 200, 200);
    @(posedge clk); @(negedge clk);
    scramble(0);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    o = get(0);
    chk("midmul_rst_out_valid", 32'(o.ov), 32'd0);
    chk("midmul_rst_y", o.y, 32'd0);
    chk("midmul_rst_y_hi", o.y_hi, 32'd0);
    chk("midmul_rst_flags", 32'(o.f), 32'd0);
    chk("midmul_rst_in_ready", 32'(o.ir), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    o = get(0);
    chk("midmul_idle_after_rst", 32'(o.ir), 32'd1);
    any_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid8) any_valid = 1'b1;
    end
    chk("midmul_no_valid_pulse", 32'(any_valid), 32'd0);
    run_op(mk(20, 0, 3'b000, 1, 1, 2, 0, 4'b0000, 1, 0));

    run_op(tbl[14]);
    run_op(tbl[15]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 8-bit combinational `alu8`. It takes operands and an opcode through a valid/ready input port and executes single-cycle logic/arithmetic ops or a multi-cycle shift-add multiply. It returns a registered result with a full flag set (carry, zero, negative, overflow) through a valid/ready output port. It sits between the operand/register-file side and the writeback stage of the CPU datapath.

## Interface
- `WIDTH`, 8, operand/result width in bits; legal values 4..32.
- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand/op presented.
- `in_ready`  out  1  block can accept an operation.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `op`  in  3  opcode (see Operation).
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer takes result.
- `y`  out  WIDTH  result (low word for MUL).
- `y_hi`  out  WIDTH  high word of MUL product; 0 for all other ops.
- `carry`, `zero`, `neg`, `ovf`  out  1 each  flags.

## Operation
- Opcodes. Codes 00x–011 are compatible with `alu8` when the op MSB is 0.
  - 000 ADD
  - 001 AND
  - 010 OR
  - 011 XOR
  - 100 SUB (a−b)
  - 101 SHL1 (a<<1)
  - 110 SHR1 (logical, a>>1)
  - 111 MUL (unsigned a×b, 2·WIDTH-bit product)
- FSM states:
  - IDLE: `in_ready`=1. On an accept (`in_valid`&&`in_ready`), latch a, b, op. Go to BUSY if op=MUL, else to DONE.
  - BUSY: shift-add multiply, one multiplier bit per cycle, WIDTH iterations via an internal counter. Go to DONE after the last iteration.
  - DONE: `out_valid`=1, all outputs held stable. On `out_ready`=1, go to IDLE.
- `in_ready` is 1 only in IDLE and is 0 while `rst`=1. No new accept occurs in the cycle the result is taken; maximum throughput is one op per 2 cycles.
- Operands and op are latched at accept; changes on `a`/`b`/`op` afterwards are ignored until the next accept.
- Arithmetic and width rules (all results truncated to WIDTH):
  - ADD: `carry` = bit WIDTH of a+b. `ovf` = signed overflow (operand signs equal, result sign differs).
  - SUB: computed as a+~b+1. `carry` = borrow = 1 iff a<b unsigned. `ovf` = signed overflow (operand signs differ, result sign differs from a).
  - SHL1: `carry` = a[WIDTH-1]. SHR1: `carry` = a[0]. `ovf`=0 for both.
  - AND/OR/XOR: `carry`=0, `ovf`=0.
  - MUL: `y` = product[WIDTH-1:0], `y_hi` = product[2·WIDTH-1:WIDTH], `carry` = (`y_hi`≠0), `ovf`=0.
  - All ops: `zero` = (`y`==0), `neg` = `y`[WIDTH-1].
- Reset:
  - Reset values: state IDLE; `out_valid`=0, `y`=0, `y_hi`=0, all flags 0; MUL counter and accumulator cleared.
  - Reset in any state, including mid-MUL or DONE with `out_ready` low, aborts the operation. No `out_valid` pulse is produced for the aborted op.
- `in_valid` asserted outside IDLE is ignored, not queued.

## Timing
- Accept at edge N. Single-cycle ops: `out_valid`=1 from edge N+1.
- MUL accepted at edge N: `out_valid`=1 from edge N+WIDTH+1 (9 cycles for WIDTH=8).
- `out_valid` stays high until the edge where `out_ready`=1. `out_valid` falls and `in_ready` rises after that edge.
- All outputs are registered; no combinational path from inputs to `y`, `y_hi` or the flags.
- `in_ready` is decoded from state only; there is no combinational path from `out_ready` to `in_ready`.
- First accept is possible on the first edge after `rst` deasserts.

## Test plan
- WIDTH=8, ADD 3+5 → `y`=8, carry=0, zero=0. ADD 200+100 → `y`=44, carry=1, ovf=0. ADD 100+100 → `y`=200, ovf=1, neg=1. In all three, `out_valid` is high exactly 1 cycle after accept.
- WIDTH=8, SUB 5−7 → `y`=254, carry=1, neg=1. SUB 9−9 → `y`=0, zero=1, carry=0. AND 3&5=1, OR 7|8=15, XOR 15^1=14, SHL1 0x81 → 0x02 with carry=1.
- WIDTH=8, MUL 200×200 → `y`=0x40, `y_hi`=0x9C, carry=1; `out_valid` first high 9 cycles after accept. MUL 15×17 → `y`=255, `y_hi`=0, carry=0. Toggling `a`/`b` during BUSY does not change the result.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → outputs stable, `in_ready`=0, and an `in_valid` pulse in that window is ignored. Raise `out_ready` → `in_ready`=1 the next cycle.
- Reset mid-MUL: assert `rst` 4 cycles after a MUL accept → next cycle state IDLE, `out_valid`=0, all outputs 0. A subsequent ADD 1+1 gives `y`=2.
- WIDTH=16 instance: ADD 0xFFFF+1 → `y`=0, zero=1, carry=1. MUL 0xFFFF×0xFFFF → `y`=0x0001, `y_hi`=0xFFFE, `out_valid` 17 cycles after accept.
